// File: rtl/gate_truth_table_checker.sv
// Truth-table stimulus/response checker for the six two-input gates.
// Walks {a,b} through 00..11 and scores each gate output against golden values.
module gate_truth_table_checker #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       or_,
   input  logic       and_,
   input  logic       nor_,
   input  logic       nand_,
   input  logic       xor_,
   input  logic       xnor_,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [5:0] fail_mask,
   output logic [4:0] err_count,
   output logic [1:0] vec_idx
);

   localparam int unsigned NUM_GATES = 6;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned ERR_W     = 5;
   localparam int unsigned MISS_W    = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                 state;
   logic [CNT_W-1:0]       settle_cnt;
   logic [NUM_GATES-1:0]   gold_c;
   logic [NUM_GATES-1:0]   got_c;
   logic [NUM_GATES-1:0]   miss_c;
   logic [MISS_W-1:0]      miss_cnt_c;

   // Golden response and per-gate mismatch; an X/Z input never equals a known golden bit.
   always_comb begin
      gold_c     = {~(a ^ b), a ^ b, ~(a & b), ~(a | b), a & b, a | b};
      got_c      = {xnor_, xor_, nand_, nor_, and_, or_};
      miss_c     = '0;
      miss_cnt_c = '0;
      for (int i = 0; i < NUM_GATES; i++) begin
         miss_c[i]  = (got_c[i] !== gold_c[i]);
         miss_cnt_c = miss_cnt_c + MISS_W'(miss_c[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         a          <= 1'b0;
         b          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         fail_mask  <= '0;
         err_count  <= '0;
         vec_idx    <= '0;
         settle_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  vec_idx    <= '0;
                  a          <= 1'b0;
                  b          <= 1'b0;
                  settle_cnt <= CNT_W'(SETTLE_CYCLES);
                  fail_mask  <= '0;
                  err_count  <= '0;
                  pass       <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SETTLE;
               end
            end
            SETTLE: begin
               settle_cnt <= settle_cnt - CNT_W'(1);
               if (settle_cnt == CNT_W'(1)) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               fail_mask <= fail_mask | miss_c;
               err_count <= err_count + ERR_W'(miss_cnt_c);
               if (vec_idx == 2'd3) begin
                  state <= DONE;
               end else begin
                  vec_idx    <= vec_idx + 2'd1;
                  {a, b}     <= vec_idx + 2'd1;
                  settle_cnt <= CNT_W'(SETTLE_CYCLES);
                  state      <= SETTLE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               pass  <= (err_count == '0);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
